// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: N CALC cycles, one DONE cycle, then a done pulse
// carrying the signed 2N-bit product.
module booth_mult_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] P
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_reg, state_next;
   logic [N:0]       m_reg;
   logic [N:0]       acc_reg;
   logic [N-1:0]     q_reg;
   logic             q1_reg;
   logic [CW-1:0]    count_reg;
   logic [2*N-1:0]   p_reg;
   logic             done_reg;

   logic             load, step, finish;
   logic             sub, add_en;
   logic [N:0]       m_op;
   logic [N:0]       sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // count_reg == 1 in CALC means this cycle performs the final step.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (count_reg == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy = (state_reg != IDLE) | done_reg;
   end

   // Booth pair {Q[0],Q_1}: 10 subtracts M, 01 adds M, 00/11 leave ACC alone.
   assign sub    = q_reg[0] & ~q1_reg;
   assign add_en = q_reg[0] ^ q1_reg;

   for (genvar gi = 0; gi <= N; gi++) begin : g_mop
      assign m_op[gi] = m_reg[gi] ^ sub;
   end

   always_comb begin
      sum = acc_reg;
      if (add_en) begin
         sum = acc_reg + m_op + {{N{1'b0}}, sub};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_reg     <= '0;
         acc_reg   <= '0;
         q_reg     <= '0;
         q1_reg    <= 1'b0;
         count_reg <= '0;
         p_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (load) begin
            m_reg     <= {A[N-1], A};
            acc_reg   <= '0;
            q_reg     <= B;
            q1_reg    <= 1'b0;
            count_reg <= CW'(N);
         end else if (step) begin
            acc_reg   <= {sum[N], sum[N:1]};
            q_reg     <= {sum[0], q_reg[N-1:1]};
            q1_reg    <= q_reg[0];
            count_reg <= count_reg - CW'(1);
         end else if (finish) begin
            p_reg    <= {acc_reg[N-1:0], q_reg};
            done_reg <= 1'b1;
         end
      end
   end

   assign done = done_reg;
   assign P    = p_reg;

endmodule
